// File: rtl/spi_burst_ctrl_if.sv
// Host-side and SPI-master-side signal bundle for spi_burst_ctrl.
// The controller connects through the slave modport. A host or testbench
// driving the controller uses the master modport.
interface spi_burst_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  // TX FIFO write side
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_full;
  logic [LW-1:0] tx_level;
  // RX FIFO read side (first-word-fall-through)
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  // SPI master handshake
  logic          m_start;
  logic [7:0]    m_data_in;
  logic [7:0]    m_data_out;
  logic          m_done;
  // Status and sticky errors
  logic          busy;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          tmo;
  logic          clr_err;

  modport slave (
    input  wr_en, wr_data, rd_en, m_data_out, m_done, clr_err,
    output tx_full, tx_level, rd_data, rx_empty, rx_level,
           m_start, m_data_in, busy, tx_ovf, rx_ovf, tmo
  );

  modport master (
    output wr_en, wr_data, rd_en, m_data_out, m_done, clr_err,
    input  tx_full, tx_level, rd_data, rx_empty, rx_level,
           m_start, m_data_in, busy, tx_ovf, rx_ovf, tmo
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: queues host bytes in a TX FIFO and feeds them one at a time
// to an SPI master. Each received byte goes into an RX FIFO. A minimum idle
// gap is enforced between transfers, and a transfer that the master never
// completes is aborted. Overflow and timeout events latch sticky flags.
module spi_burst_ctrl #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            reset,
  spi_burst_ctrl_if.slave bus
);
  localparam int            AW        = $clog2(DEPTH);
  localparam int            LW        = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [15:0]   XFER_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, GAP} state_e;

  state_e        state_q;
  logic          m_start_q;
  logic [7:0]    m_data_in_q;
  logic [15:0]   xfer_cnt_q;
  logic [7:0]    gap_cnt_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [LW-1:0] tx_level_q, tx_level_d;
  logic [LW-1:0] rx_level_q, rx_level_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          tmo_q, tmo_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_push, rx_cap, rx_pop, rx_push, tmo_evt;

  assign tx_full  = (tx_level_q == FULL_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == FULL_LVL);
  assign rx_empty = (rx_level_q == '0);

  // LOAD is only entered with a non-empty TX FIFO, so its pop never underflows.
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign tx_pop  = (state_q == LOAD);
  assign tx_push = bus.wr_en && (!tx_full || tx_pop);
  assign rx_cap  = (state_q == XFER) && bus.m_done;
  assign rx_pop  = bus.rd_en && !rx_empty;
  assign rx_push = rx_cap && (!rx_full || rx_pop);
  assign tmo_evt = (state_q == XFER) && !bus.m_done && (xfer_cnt_q == XFER_LAST);

  // Occupancy next-state: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    tx_level_d = tx_level_q;
    rx_level_d = rx_level_q;
    if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LW'(1);
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LW'(1);
    if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LW'(1);
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LW'(1);
  end

  // Sticky flags: a new error event beats clr_err in the same cycle.
  always_comb begin
    tx_ovf_d = (tx_ovf_q && !bus.clr_err) || (bus.wr_en && tx_full && !tx_pop);
    rx_ovf_d = (rx_ovf_q && !bus.clr_err) || (rx_cap && rx_full && !rx_pop);
    tmo_d    = (tmo_q && !bus.clr_err) || tmo_evt;
  end

  // FIFO storage holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= bus.wr_data;
    if (rx_push) rx_mem[rx_wp_q] <= bus.m_data_out;
  end

  // FIFO pointers and levels. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      tx_level_q <= tx_level_d;
      rx_level_q <= rx_level_d;
    end
  end

  // Sticky error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  // Transfer sequencer. m_start is registered and high exactly while in XFER.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_start_q   <= 1'b0;
      m_data_in_q <= 8'h00;
      xfer_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_empty && !bus.m_done) state_q <= LOAD;
        end
        LOAD: begin
          m_data_in_q <= tx_mem[tx_rp_q];
          m_start_q   <= 1'b1;
          xfer_cnt_q  <= '0;
          state_q     <= XFER;
        end
        XFER: begin
          if (bus.m_done || tmo_evt) begin
            m_start_q <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
          end
        end
        GAP: begin
          // gap_cnt_q counts GAP cycles already completed before this one
          if (!bus.m_done && (gap_cnt_q >= GAP_LAST)) begin
            state_q <= IDLE;
          end else if (gap_cnt_q != 8'hFF) begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_full   = tx_full;
  assign bus.tx_level  = tx_level_q;
  assign bus.rd_data   = rx_mem[rx_rp_q];
  assign bus.rx_empty  = rx_empty;
  assign bus.rx_level  = rx_level_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_data_in = m_data_in_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.tx_ovf    = tx_ovf_q;
  assign bus.rx_ovf    = rx_ovf_q;
  assign bus.tmo       = tmo_q;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Testbench for spi_burst_ctrl. A transaction-level reference model uses
// byte queues and flags to predict FIFO contents, levels, error flags,
// transfer end/timeout and transmitted byte order.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_burst_ctrl_if #(.DEPTH(DEPTH)) bus();

  spi_burst_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_tx_ovf, m_rx_ovf, m_tmo;
  int         xfer_len, low_cnt, wait_cnt;
  bit         had_xfer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_in();
    bus.wr_en      = 1'b0;
    bus.wr_data    = 8'h00;
    bus.rd_en      = 1'b0;
    bus.clr_err    = 1'b0;
    bus.m_done     = 1'b0;
    bus.m_data_out = 8'h00;
  endtask

  task automatic master_loop();
    bus.m_done     = bus.m_start;
    bus.m_data_out = bus.m_data_in;
  endtask

  // One clock: apply current inputs, advance the model, compare outputs.
  task automatic step();
    logic       pre_start;
    logic [7:0] pre_din;
    logic [7:0] exp_byte;
    bit         fall, ev_tx, ev_rx, ev_tmo;
    pre_start = bus.m_start;
    pre_din   = bus.m_data_in;
    @(posedge clk);
    #1;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_tmo = 0;
      xfer_len = 0; low_cnt = 0; had_xfer = 0;
      chk("rst_start", 32'(bus.m_start), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_din", 32'(bus.m_data_in), 0);
    end else begin
      fall = 0; ev_tx = 0; ev_rx = 0; ev_tmo = 0;
      if (bus.rd_en && rx_q.size() > 0) void'(rx_q.pop_front());
      if (pre_start) begin
        if (bus.m_done) begin
          fall = 1;
          if (rx_q.size() < DEPTH) rx_q.push_back(bus.m_data_out);
          else ev_rx = 1;
        end else begin
          xfer_len++;
          if (xfer_len == TMO) begin
            fall   = 1;
            ev_tmo = 1;
          end
        end
        chk("xfer_end", 32'(bus.m_start), 32'(!fall));
        if (!fall) chk("din_stable", 32'(bus.m_data_in), 32'(pre_din));
      end else if (bus.m_start) begin
        chk("start_with_data", 32'(tx_q.size() > 0), 1);
        if (had_xfer) chk("gap_len", 32'(low_cnt >= GAP + 2), 1);
        if (tx_q.size() > 0) begin
          exp_byte = tx_q.pop_front();
          chk("din", 32'(bus.m_data_in), 32'(exp_byte));
        end
        had_xfer = 1;
        xfer_len = 0;
        low_cnt  = 0;
      end
      if (!bus.m_start) low_cnt++;
      if (bus.wr_en) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(bus.wr_data);
        else ev_tx = 1;
      end
      m_tx_ovf = (m_tx_ovf && !bus.clr_err) || ev_tx;
      m_rx_ovf = (m_rx_ovf && !bus.clr_err) || ev_rx;
      m_tmo    = (m_tmo && !bus.clr_err) || ev_tmo;
      if (bus.m_start) chk("busy_in_xfer", 32'(bus.busy), 1);
    end
    chk("tx_level", 32'(bus.tx_level), 32'(tx_q.size()));
    chk("tx_full", 32'(bus.tx_full), 32'(tx_q.size() == DEPTH));
    chk("rx_level", 32'(bus.rx_level), 32'(rx_q.size()));
    chk("rx_empty", 32'(bus.rx_empty), 32'(rx_q.size() == 0));
    if (rx_q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(rx_q[0]));
    chk("tx_ovf", 32'(bus.tx_ovf), 32'(m_tx_ovf));
    chk("rx_ovf", 32'(bus.rx_ovf), 32'(m_rx_ovf));
    chk("tmo", 32'(bus.tmo), 32'(m_tmo));
  endtask

  // Random traffic. mode 0: responsive master, 1: master never completes,
  // 2: responsive master plus stray m_done pulses outside transfers.
  task automatic run(input int cycles, input int mode, input int wr_pct,
                     input int rd_pct, input bit loopback);
    for (int c = 0; c < cycles; c++) begin
      reset       = ($urandom_range(0, 599) == 0);
      bus.wr_en   = (int'($urandom_range(0, 99)) < wr_pct);
      bus.wr_data = 8'($urandom);
      bus.rd_en   = (int'($urandom_range(0, 99)) < rd_pct);
      bus.clr_err = ($urandom_range(0, 49) == 0);
      if (mode != 1 && bus.m_start) begin
        if (wait_cnt == 0) begin
          bus.m_done     = 1'b1;
          bus.m_data_out = loopback ? bus.m_data_in : 8'($urandom);
          wait_cnt       = int'($urandom_range(0, 4));
        end else begin
          wait_cnt--;
          bus.m_done = 1'b0;
        end
      end else begin
        bus.m_done     = (mode == 2) && ($urandom_range(0, 9) == 0);
        bus.m_data_out = 8'($urandom);
      end
      step();
    end
    reset = 1'b0;
    idle_in();
  endtask

  initial begin
    wait_cnt = 0;
    idle_in();
    reset = 1'b1;
    step();
    step();
    chk("rst_tx_level", 32'(bus.tx_level), 0);
    chk("rst_rx_level", 32'(bus.rx_level), 0);
    chk("rst_tx_full", 32'(bus.tx_full), 0);
    chk("rst_rx_empty", 32'(bus.rx_empty), 1);
    chk("rst_flags", {29'd0, bus.tx_ovf, bus.rx_ovf, bus.tmo}, 0);
    reset = 1'b0;

    // single byte: start latency, captured reply, busy through the gap
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    chk("start_lat0", 32'(bus.m_start), 0);
    step();
    chk("start_lat1", 32'(bus.m_start), 0);
    step();
    chk("start_lat2", 32'(bus.m_start), 1);
    chk("single_din", 32'(bus.m_data_in), 32'h A5);
    bus.m_done = 1'b1; bus.m_data_out = 8'h3C;
    step();
    idle_in();
    chk("single_rd", 32'(bus.rd_data), 32'h3C);
    chk("single_rxlvl", 32'(bus.rx_level), 1);
    for (int k = 1; k <= GAP; k++) begin
      step();
      chk("busy_gap", 32'(bus.busy), 32'(k < GAP));
    end
    bus.rd_en = 1'b1;
    step();
    step();
    bus.rd_en = 1'b0;
    chk("rd_empty_ignored", 32'(bus.rx_ovf), 0);
    chk("rd_empty_level", 32'(bus.rx_level), 0);

    // eight back-to-back bytes through a loopback master
    for (int c = 0; c < 300; c++) begin
      bus.wr_en   = (c < 8);
      bus.wr_data = 8'(c + 1);
      master_loop();
      step();
      if (bus.rx_level == LW'(8)) break;
    end
    idle_in();
    chk("burst_rx_level", 32'(bus.rx_level), 8);
    for (int i = 0; i < 8; i++) begin
      chk("burst_order", 32'(bus.rd_data), 32'(i + 1));
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;

    // RX overflow, clear, capture with simultaneous read when full
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.wr_en   = (c < DEPTH + 1);
      bus.wr_data = 8'(8'h80 + c);
      master_loop();
      step();
      if (c >= DEPTH + 1 && !bus.busy && bus.tx_level == '0) break;
    end
    idle_in();
    chk("rxovf_set", 32'(bus.rx_ovf), 1);
    chk("rxovf_level", 32'(bus.rx_level), DEPTH);
    chk("rxovf_first", 32'(bus.rd_data), 32'h80);
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    chk("rxovf_clr", 32'(bus.rx_ovf), 0);
    for (int c = 0; c < 100; c++) begin
      bus.wr_en = (c == 0); bus.wr_data = 8'h99;
      master_loop();
      bus.rd_en = bus.m_start;
      step();
      if (c > 0 && !bus.busy) break;
    end
    idle_in();
    chk("full_cap_rd_lvl", 32'(bus.rx_level), DEPTH);
    chk("full_cap_rd_ovf", 32'(bus.rx_ovf), 0);

    // reset in the middle of a transfer
    for (int c = 0; c < 10; c++) begin
      bus.wr_en = (c < 2); bus.wr_data = 8'(8'hA1 + c);
      step();
      if (bus.m_start) break;
    end
    idle_in();
    chk("mid_xfer", 32'(bus.m_start), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_mid_start", 32'(bus.m_start), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_txlvl", 32'(bus.tx_level), 0);
    chk("rst_mid_rxlvl", 32'(bus.rx_level), 0);

    // stalled master: TX overflow, clr vs event, timeout, push+pop when full
    bus.wr_en = 1'b1; bus.wr_data = 8'h50; step();
    bus.wr_en = 1'b0; step(); step();
    chk("stall_start", 32'(bus.m_start), 1);
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
      step();
    end
    bus.wr_en = 1'b0;
    chk("txovf_level", 32'(bus.tx_level), DEPTH);
    chk("txovf_full", 32'(bus.tx_full), 1);
    chk("txovf_set", 32'(bus.tx_ovf), 1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h70; bus.clr_err = 1'b1; step();
    chk("clr_vs_event", 32'(bus.tx_ovf), 1);
    bus.wr_en = 1'b0; step(); bus.clr_err = 1'b0;
    chk("clr_err", 32'(bus.tx_ovf), 0);
    for (int n = 0; n < TMO + 5 && bus.m_start; n++) step();
    chk("tmo_end", 32'(bus.m_start), 0);
    chk("tmo_set", 32'(bus.tmo), 1);
    chk("tmo_no_rx", 32'(bus.rx_level), 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h71;
    for (int n = 0; n < 20 && !bus.m_start; n++) step();
    bus.wr_en = 1'b0;
    chk("next_start", 32'(bus.m_start), 1);
    chk("next_din", 32'(bus.m_data_in), 32'h60);
    chk("push_pop_full", 32'(bus.tx_level), DEPTH);

    // randomized traffic against the model
    run(1500, 0, 30, 30, 1'b0);
    run(1000, 0, 70, 10, 1'b1);
    run(800,  2, 40, 50, 1'b1);
    run(400,  1, 50, 20, 1'b0);
    run(800,  0, 20, 80, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
